// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared types and helpers for the issue scoreboard.
//   unit_t        : execution class of the instruction at pipe 3
//   DEF_*_LAT     : default result latencies per execution class
//   unit_latency  : maps an execution class to its result latency
//   max2          : larger of two 2-bit counter values
// -----------------------------------------------------------------------------
package sb_pkg;

    typedef enum logic [1:0] {
        UNIT_ALU    = 2'd0,
        UNIT_MEM    = 2'd1,
        UNIT_MULDIV = 2'd2,
        UNIT_CSR    = 2'd3
    } unit_t;

    localparam int DEF_ALU_LAT    = 1;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_MULDIV_LAT = 3;
    localparam int DEF_CSR_LAT    = 1;

    localparam int NUM_REGS = 32;

    function automatic logic [1:0] unit_latency(
        input unit_t      u,
        input logic [1:0] alu_lat    = 2'(DEF_ALU_LAT),
        input logic [1:0] mem_lat    = 2'(DEF_MEM_LAT),
        input logic [1:0] muldiv_lat = 2'(DEF_MULDIV_LAT),
        input logic [1:0] csr_lat    = 2'(DEF_CSR_LAT)
    );
        logic [1:0] lat;
        case (u)
            UNIT_ALU:    lat = alu_lat;
            UNIT_MEM:    lat = mem_lat;
            UNIT_MULDIV: lat = muldiv_lat;
            default:     lat = csr_lat;
        endcase
        return lat;
    endfunction

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// One 2-bit countdown counter. Priority: load, then clear, then decrement.
//   clk        : core clock
//   nrst       : asynchronous active-low reset (counter -> 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load
//   clear_i    : force the counter to 0 this cycle
//   cnt_o      : current counter value
// -----------------------------------------------------------------------------
module sb_entry (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       clear_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clear_i) begin
            cnt_d = 2'd0;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// Register/structural hazard scheduler between decode (pipe 3) and issue
// (pipe 4). Pending register writes are tracked with per-register countdown
// counters; a mul/div occupancy counter covers the non-pipelined unit.
//   clk, nrst            : clock, asynchronous active-low reset
//   issue_valid          : valid instruction at pipe 3
//   rs1/rs2, rs*_used    : source addresses and their use flags
//   rd3, we3             : destination address and write enable
//   unit3                : execution class (unit_t)
//   bjtaken, exception   : flush requests from execute
//   stall                : freeze pipes 1-3, bubble into pipe 4
//   stallnum             : remaining stall cycles for the active hazard
//   busy_vec             : per-register pending-write flags (bit 0 always 0)
// -----------------------------------------------------------------------------
module issue_scoreboard
    import sb_pkg::*;
#(
    parameter int ALU_LAT    = DEF_ALU_LAT,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int MULDIV_LAT = DEF_MULDIV_LAT,
    parameter int CSR_LAT    = DEF_CSR_LAT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        issue_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  rd3,
    input  logic        we3,
    input  unit_t       unit3,
    input  logic        bjtaken,
    input  logic        exception,
    output logic        stall,
    output logic [1:0]  stallnum,
    output logic [31:0] busy_vec
);

    // Latencies must fit the 2-bit counters and be nonzero, otherwise a
    // dependent instruction could issue before the result is readable.
    if (ALU_LAT < 1 || ALU_LAT > 3 || MEM_LAT < 1 || MEM_LAT > 3 ||
        MULDIV_LAT < 1 || MULDIV_LAT > 3 || CSR_LAT < 1 || CSR_LAT > 3) begin : g_bad_lat
        $error("issue_scoreboard: latency parameters must be in 1..3");
    end

    localparam logic [1:0] ALU_L = 2'(ALU_LAT);
    localparam logic [1:0] MEM_L = 2'(MEM_LAT);
    localparam logic [1:0] MD_L  = 2'(MULDIV_LAT);
    localparam logic [1:0] CSR_L = 2'(CSR_LAT);

    logic [31:0][1:0] cnt_q;
    logic [1:0]       md_cnt_q;

    logic             last_valid_q, last_valid_d;
    logic [4:0]       last_rd_q,    last_rd_d;
    logic             last_md_q,    last_md_d;

    logic             flush;
    logic             raw1, raw2, waw, struct_hz;
    logic [1:0]       hazard_num;
    logic             alloc;
    logic             wr_alloc;
    logic             md_alloc;
    logic             md_clear;
    logic [1:0]       alloc_lat;
    logic [31:1]      load_vec;
    logic [31:1]      clear_vec;

    // x0 has no counter; it reads as permanently idle.
    assign cnt_q[0] = 2'd0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        sb_entry u_entry (
            .clk        (clk),
            .nrst       (nrst),
            .load_i     (load_vec[r]),
            .load_val_i (alloc_lat),
            .clear_i    (clear_vec[r]),
            .cnt_o      (cnt_q[r])
        );
    end

    sb_entry u_md (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (md_alloc),
        .load_val_i (MD_L),
        .clear_i    (md_clear),
        .cnt_o      (md_cnt_q)
    );

    assign flush     = bjtaken | exception;

    assign raw1      = rs1_used && (rs1 != 5'd0) && (cnt_q[rs1] != 2'd0);
    assign raw2      = rs2_used && (rs2 != 5'd0) && (cnt_q[rs2] != 2'd0);
    assign waw       = we3 && (rd3 != 5'd0) && (cnt_q[rd3] != 2'd0);
    assign struct_hz = (unit3 == UNIT_MULDIV) && (md_cnt_q != 2'd0);

    assign stall     = issue_valid && !flush && (raw1 || raw2 || waw || struct_hz);

    // Stall length is set by the slowest of the hazards currently active.
    always_comb begin
        hazard_num = 2'd0;
        if (raw1)      hazard_num = max2(hazard_num, cnt_q[rs1]);
        if (raw2)      hazard_num = max2(hazard_num, cnt_q[rs2]);
        if (waw)       hazard_num = max2(hazard_num, cnt_q[rd3]);
        if (struct_hz) hazard_num = max2(hazard_num, md_cnt_q);
    end

    assign stallnum  = stall ? hazard_num : 2'd0;

    assign alloc     = issue_valid && !stall && !flush;
    assign wr_alloc  = alloc && we3 && (rd3 != 5'd0);
    assign md_alloc  = alloc && (unit3 == UNIT_MULDIV);
    assign alloc_lat = unit_latency(unit3, ALU_L, MEM_L, MD_L, CSR_L);

    // On a flush only the instruction allocated last cycle (now in pipe 4)
    // is killed; older writers are already past the flush point.
    assign md_clear  = flush && last_md_q;

    always_comb begin
        load_vec  = '0;
        clear_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            load_vec[r]  = wr_alloc && (rd3 == 5'(r));
            clear_vec[r] = flush && last_valid_q && (last_rd_q == 5'(r));
        end
    end

    always_comb begin
        last_valid_d = wr_alloc;
        last_rd_d    = wr_alloc ? rd3 : last_rd_q;
        last_md_d    = md_alloc;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_valid_q <= 1'b0;
            last_rd_q    <= 5'd0;
            last_md_q    <= 1'b0;
        end else begin
            last_valid_q <= last_valid_d;
            last_rd_q    <= last_rd_d;
            last_md_q    <= last_md_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt_q[r] != 2'd0);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
    import sb_pkg::*;

    logic        clk;
    logic        nrst;
    logic        issue_valid;
    logic [4:0]  rs1, rs2, rd3;
    logic        rs1_used, rs2_used, we3;
    unit_t       unit3;
    logic        bjtaken, exception;
    logic        stall;
    logic [1:0]  stallnum;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    issue_scoreboard dut (
        .clk         (clk),
        .nrst        (nrst),
        .issue_valid (issue_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .rd3         (rd3),
        .we3         (we3),
        .unit3       (unit3),
        .bjtaken     (bjtaken),
        .exception   (exception),
        .stall       (stall),
        .stallnum    (stallnum),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        rs1 = 5'd0; rs1_used = 1'b0;
        rs2 = 5'd0; rs2_used = 1'b0;
        rd3 = 5'd0; we3 = 1'b0;
        unit3 = UNIT_ALU;
        bjtaken = 1'b0; exception = 1'b0;
    endtask

    task automatic instr(input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2,
                         input logic [4:0] d,  input logic w, input unit_t u);
        issue_valid = 1'b1;
        rs1 = a1; rs1_used = u1;
        rs2 = a2; rs2_used = u2;
        rd3 = d;  we3 = w;
        unit3 = u;
    endtask

    task automatic drain;
        idle();
        repeat (4) cyc();
    endtask

    task automatic test_reset;
        cyc(); cyc();
        instr(5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, UNIT_MULDIV);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (stallnum !== 2'd0) begin errors++; $display("FAIL reset_stallnum: got %0d expected 0", stallnum); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
        idle();
        #2 nrst = 1'b1;
        cyc();
    endtask

    task automatic test_raw_alu;
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, UNIT_ALU);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_alloc_stall: got %b expected 0", stall); end
        cyc();
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, UNIT_ALU);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
        checks++; if (stallnum !== 2'd1) begin errors++; $display("FAIL raw_stallnum: got %0d expected 1", stallnum); end
        checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy: got %h expected 00000020", busy_vec); end
        cyc();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall: got %b expected 0", stall); end
        cyc();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0040) begin errors++; $display("FAIL raw_issue_busy: got %h expected 00000040", busy_vec); end
        drain();
    endtask

    task automatic test_load_use;
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, UNIT_MEM);
        cyc();
        instr(5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, UNIT_ALU);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall0: got %b expected 1", stall); end
        checks++; if (stallnum !== 2'd2) begin errors++; $display("FAIL lu_stallnum0: got %0d expected 2", stallnum); end
        cyc();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %b expected 1", stall); end
        checks++; if (stallnum !== 2'd1) begin errors++; $display("FAIL lu_stallnum1: got %0d expected 1", stallnum); end
        cyc();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_issue: got %b expected 0", stall); end
        cyc();
        // x0 is never allocated and never hazards.
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, UNIT_MEM);
        cyc();
        instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, UNIT_ALU);
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h expected 0", busy_vec); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", stall); end
        drain();
    endtask

    task automatic test_struct;
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, UNIT_MULDIV);
        cyc();
        instr(5'd12, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, UNIT_MULDIV);
        #1;
        checks++; if (stall !== 1'b1 || stallnum !== 2'd3) begin errors++; $display("FAIL md_c0: got stall %b num %0d expected 1/3", stall, stallnum); end
        cyc();
        checks++; if (stall !== 1'b1 || stallnum !== 2'd2) begin errors++; $display("FAIL md_c1: got stall %b num %0d expected 1/2", stall, stallnum); end
        cyc();
        checks++; if (stall !== 1'b1 || stallnum !== 2'd1) begin errors++; $display("FAIL md_c2: got stall %b num %0d expected 1/1", stall, stallnum); end
        cyc();
        checks++; if (stall !== 1'b0 || stallnum !== 2'd0) begin errors++; $display("FAIL md_issue: got stall %b num %0d expected 0/0", stall, stallnum); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL md_issue_busy: got %h expected 0", busy_vec); end
        cyc();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0800) begin errors++; $display("FAIL md_after_busy: got %h expected 00000800", busy_vec); end
        drain();
    endtask

    task automatic test_flush;
        // Youngest register write is killed.
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, UNIT_MEM);
        cyc();
        instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, UNIT_MEM);
        bjtaken = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL flush_busy_pre: got %h expected 00000200", busy_vec); end
        cyc();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush_busy_post: got %h expected 0", busy_vec); end
        cyc();
        // Youngest mul/div is killed together with its occupancy.
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, UNIT_MULDIV);
        cyc();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, UNIT_MULDIV);
        exception = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exc_stall: got %b expected 0", stall); end
        cyc();
        exception = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL exc_md_cleared: got %b expected 0", stall); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL exc_busy: got %h expected 0", busy_vec); end
        cyc();
        drain();
        // Older writer and older mul/div survive a flush.
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, UNIT_MULDIV);
        cyc();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, UNIT_ALU);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL old_alloc_stall: got %b expected 0", stall); end
        cyc();
        idle();
        bjtaken = 1'b1;
        #1;
        checks++; if (busy_vec !== 32'h0000_C000) begin errors++; $display("FAIL old_busy_pre: got %h expected 0000c000", busy_vec); end
        cyc();
        bjtaken = 1'b0;
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, UNIT_MULDIV);
        #1;
        checks++; if (busy_vec !== 32'h0000_4000) begin errors++; $display("FAIL old_busy_post: got %h expected 00004000", busy_vec); end
        checks++; if (stall !== 1'b1 || stallnum !== 2'd1) begin errors++; $display("FAIL old_md_kept: got stall %b num %0d expected 1/1", stall, stallnum); end
        cyc();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL old_md_issue: got %b expected 0", stall); end
        cyc();
        drain();
    endtask

    task automatic test_waw_reset;
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, UNIT_MEM);
        cyc();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, UNIT_ALU);
        #1;
        checks++; if (stall !== 1'b1 || stallnum !== 2'd2) begin errors++; $display("FAIL waw_c0: got stall %b num %0d expected 1/2", stall, stallnum); end
        cyc();
        checks++; if (stall !== 1'b1 || stallnum !== 2'd1) begin errors++; $display("FAIL waw_c1: got stall %b num %0d expected 1/1", stall, stallnum); end
        nrst = 1'b0;
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL waw_rst_busy: got %h expected 0", busy_vec); end
        checks++; if (stall !== 1'b0 || stallnum !== 2'd0) begin errors++; $display("FAIL waw_rst_stall: got stall %b num %0d expected 0/0", stall, stallnum); end
        idle();
        cyc();
        #2 nrst = 1'b1;
        cyc();
    endtask

    initial begin
        nrst = 1'b0;
        idle();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_struct();
        test_flush();
        test_waw_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
